// File: rtl/dmem_hs_if.sv
// Request/response bundle between the MEM stage (master) and dmem_hs (slave).
// Master holds req and the request fields until it sees ready; completion is a one-cycle rvalid.
interface dmem_hs_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_hs.sv
// Byte-enabled data memory with req/ready/rvalid handshake; access LATENCY edges after accept, rvalid the cycle after.
// Backpressure: ready drops for LATENCY cycles per accepted request; requests are not queued.
module dmem_hs #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  dmem_hs_if.slave   bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic                accept;
  logic                do_access;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic                in_range;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign bus.ready = (state == IDLE);
  // reset_n gating keeps a zero-latency request from writing memory while reset is held
  assign accept    = bus.req && bus.ready && reset_n;
  assign in_range  = ({1'b0, acc_addr} < DEPTH_L);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            do_access = 1'b1;
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_be    = bus.be;
          end else begin
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bus.rvalid <= do_access;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
      end
      if (do_access) begin
        bus.err   <= !in_range;
        bus.rdata <= (!acc_we && in_range) ? mem[acc_addr] : '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_access && acc_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: three instances (LATENCY 1/DEPTH 200, LATENCY 0, LATENCY 3) against a word-array model.
module tb_dmem_hs;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n   [3];
  logic        req_s   [3];
  logic        we_s    [3];
  logic [7:0]  addr_s  [3];
  logic [15:0] wdata_s [3];
  logic [1:0]  be_s    [3];
  logic        ready_s [3];
  logic        rvalid_s[3];
  logic        err_s   [3];
  logic [15:0] rdata_s [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [3][256];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? 200 : 256;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_hs_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    dmem_hs #(
      .DATA_W (16),
      .ADDR_W (8),
      .DEPTH  ((g == 0) ? 200 : 256),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clock  (clock),
      .reset_n(rst_n[g]),
      .bus    (bus)
    );
    assign bus.req     = req_s[g];
    assign bus.we      = we_s[g];
    assign bus.addr    = addr_s[g];
    assign bus.wdata   = wdata_s[g];
    assign bus.be      = be_s[g];
    assign ready_s[g]  = bus.ready;
    assign rvalid_s[g] = bus.rvalid;
    assign rdata_s[g]  = bus.rdata;
    assign err_s[g]    = bus.err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: wait for ready, accept, then time and check the response.
  task automatic txn(input int d, input bit w, input logic [7:0] a, input logic [15:0] wd,
                     input logic [1:0] b, input string tag);
    logic [15:0] exp_rd;
    bit          exp_err;
    int          n;
    exp_err = (int'(a) >= dep_of(d));
    exp_rd  = (!w && !exp_err) ? mdl[d][a] : 16'h0000;
    if (w && !exp_err)
      for (int l = 0; l < 2; l++)
        if (b[l]) mdl[d][a][8*l +: 8] = wd[8*l +: 8];
    @(negedge clock);
    req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = b;
    n = 0;
    while (!ready_s[d] && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready_pre"}, 32'(ready_s[d]), 32'd1);
    @(posedge clock); #1;
    req_s[d] = 1'b0;
    check({tag, "_ready_post"}, 32'(ready_s[d]), 32'(lat_of(d) == 0));
    n = 0;
    while (!rvalid_s[d] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat_of(d)));
    check({tag, "_err"}, 32'(err_s[d]), 32'(exp_err));
    check({tag, "_rdata"}, 32'(rdata_s[d]), 32'(exp_rd));
    check({tag, "_ready_done"}, 32'(ready_s[d]), 32'd1);
    @(posedge clock); #1;
    check({tag, "_pulse"}, 32'(rvalid_s[d]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pend;
    logic [7:0]  ha;
    int          rv_seen;

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_s[d] = 1'b0; we_s[d] = 1'b0;
      addr_s[d] = 8'h00; wdata_s[d] = 16'h0000; be_s[d] = 2'b00;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", 32'(ready_s[d]), 32'd1);
      check("rst_rvalid", 32'(rvalid_s[d]), 32'd0);
      check("rst_rdata", 32'(rdata_s[d]), 32'd0);
      check("rst_err", 32'(err_s[d]), 32'd0);
    end
    @(negedge clock);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++)
        txn(d, 1'b1, 8'(a), 16'($urandom()), 2'b11, "preload");

    // LATENCY 1 basic store/load and byte lanes
    txn(0, 1'b1, 8'h10, 16'hBEEF, 2'b11, "st10");
    txn(0, 1'b0, 8'h10, 16'h0000, 2'b00, "ld10");
    check("ld10_const", 32'(rdata_s[0]), 32'h0000BEEF);
    txn(0, 1'b1, 8'h20, 16'h1234, 2'b11, "st20_full");
    txn(0, 1'b1, 8'h20, 16'hAB00, 2'b10, "st20_hi");
    txn(0, 1'b0, 8'h20, 16'h0000, 2'b00, "ld20_a");
    check("ld20_a_const", 32'(rdata_s[0]), 32'h0000AB34);
    txn(0, 1'b1, 8'h20, 16'hFFFF, 2'b00, "st20_be0");
    txn(0, 1'b0, 8'h20, 16'h0000, 2'b00, "ld20_b");
    check("ld20_b_const", 32'(rdata_s[0]), 32'h0000AB34);

    // out-of-range on DEPTH 200
    txn(0, 1'b0, 8'hC8, 16'h0000, 2'b00, "ld_c8");
    check("ld_c8_err_const", 32'(err_s[0]), 32'd1);
    txn(0, 1'b1, 8'hC8, 16'h7777, 2'b11, "st_c8");
    txn(0, 1'b0, 8'hC7, 16'h0000, 2'b00, "ld_c7");

    // LATENCY 0 back-to-back stream
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      req_s[1] = 1'b1; we_s[1] = (i % 2 == 0); addr_s[1] = 8'h05;
      wdata_s[1] = 16'(i / 2 + 1); be_s[1] = 2'b11;
      if (i % 2 == 0) mdl[1][5] = 16'(i / 2 + 1);
      pend = (i % 2 == 0) ? 16'h0000 : mdl[1][5];
      check("b2b_ready", 32'(ready_s[1]), 32'd1);
      @(posedge clock); #1;
      check("b2b_rvalid", 32'(rvalid_s[1]), 32'd1);
      check("b2b_rdata", 32'(rdata_s[1]), 32'(pend));
    end
    req_s[1] = 1'b0;
    check("b2b_ld2_const", 32'(rdata_s[1]), 32'h00000002);
    @(posedge clock); #1;
    check("b2b_idle", 32'(rvalid_s[1]), 32'd0);

    // LATENCY 3: req held through WAIT with a changing address
    pend = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      ha = 8'($urandom());
      req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = ha; be_s[2] = 2'b11;
      if (c % 4 == 0) pend = mdl[2][ha];
      check("hold_ready", 32'(ready_s[2]), 32'(c % 4 == 0));
      @(posedge clock); #1;
      check("hold_rvalid", 32'(rvalid_s[2]), 32'(c % 4 == 3));
      if (c % 4 == 3) check("hold_rdata", 32'(rdata_s[2]), 32'(pend));
    end
    req_s[2] = 1'b0;
    @(posedge clock); #1;
    check("hold_after", 32'(rvalid_s[2]), 32'd0);

    // LATENCY 3: reset during WAIT aborts the pending store
    txn(2, 1'b1, 8'h30, 16'h0000, 2'b11, "pre30");
    txn(2, 1'b1, 8'h31, 16'hA5A5, 2'b11, "st31");
    txn(2, 1'b0, 8'h31, 16'h0000, 2'b00, "ld31");
    @(negedge clock);
    req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 8'h30; wdata_s[2] = 16'h5555; be_s[2] = 2'b11;
    check("abort_ready_pre", 32'(ready_s[2]), 32'd1);
    @(posedge clock); #1;
    req_s[2] = 1'b0;
    rv_seen = 0;
    @(posedge clock); #1;
    rv_seen += int'(rvalid_s[2]);
    @(negedge clock);
    rst_n[2] = 1'b0;
    #1;
    check("abort_ready", 32'(ready_s[2]), 32'd1);
    check("abort_rvalid", 32'(rvalid_s[2]), 32'd0);
    check("abort_rdata", 32'(rdata_s[2]), 32'd0);
    check("abort_err", 32'(err_s[2]), 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
      rv_seen += int'(rvalid_s[2]);
    end
    @(negedge clock);
    rst_n[2] = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      rv_seen += int'(rvalid_s[2]);
    end
    check("abort_no_rvalid", 32'(rv_seen), 32'd0);
    txn(2, 1'b0, 8'h30, 16'h0000, 2'b00, "ld30");
    check("ld30_const", 32'(rdata_s[2]), 32'h00000000);

    // randomized traffic on every instance
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 60; k++)
        txn(d, 1'($urandom()), 8'($urandom()), 16'($urandom()), 2'($urandom()), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
